// File: rtl/div_pkg.sv
// Shared types and constants for the iterative non-restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIXUP,
        DIV_DONE
    } div_state_e;

    // Sliced down to DATA_WIDTH by the user; supports widths up to 64.
    localparam logic [63:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_step_nonrestore.sv
// One radix-2 non-restoring iteration: shift {P,Q}, add or subtract D, set the quotient bit.
// Latency: purely combinational.
// Backpressure: none; sequencing is owned by the caller.
module div_step_nonrestore #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   p,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH:0]   p_next,
    output logic [DATA_WIDTH-1:0] q_next
);

    logic                sub;
    logic [DATA_WIDTH:0] a;
    logic [DATA_WIDTH:0] b;
    logic [DATA_WIDTH:0] c;

    // The add/subtract decision follows the sign of P before the shift.
    assign sub  = ~p[DATA_WIDTH];
    assign a    = {p[DATA_WIDTH-1:0], q[DATA_WIDTH-1]};
    assign b    = sub ? ~{1'b0, d} : {1'b0, d};
    assign c[0] = sub;

    for (genvar i = 0; i <= DATA_WIDTH; i++) begin : g_fa
        assign p_next[i] = a[i] ^ b[i] ^ c[i];
        if (i < DATA_WIDTH) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign q_next = {q[DATA_WIDTH-2:0], ~p_next[DATA_WIDTH]};

endmodule

// File: rtl/div_32bit_nonrestore.sv
// Iterative signed/unsigned divider producing a truncated quotient and a dividend-signed remainder.
// Latency: DATA_WIDTH+2 cycles to o_vld; divide-by-zero and signed overflow resolve in 1 cycle.
// Backpressure: one operation in flight; o_rdy only in IDLE, result held in DONE until i_rdy.
module div_32bit_nonrestore
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic                  i_sign,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [DATA_WIDTH-1:0] o_quo,
    output logic [DATA_WIDTH-1:0] o_rem,
    output logic                  o_busy
);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_e            state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH:0]   p_reg;
    logic [DATA_WIDTH-1:0] q_reg;
    logic [DATA_WIDTH-1:0] d_reg;
    logic                  quo_neg;
    logic                  rem_neg;

    logic [DATA_WIDTH:0]   p_step;
    logic [DATA_WIDTH-1:0] q_step;
    logic [DATA_WIDTH:0]   p_fix;
    logic [DATA_WIDTH-1:0] quo_fix;
    logic [DATA_WIDTH-1:0] rem_fix;
    logic [DATA_WIDTH-1:0] dvd_mag;
    logic [DATA_WIDTH-1:0] dvs_mag;
    logic                  dvs_zero;
    logic                  ovf;

    div_step_nonrestore #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .p      (p_reg),
        .q      (q_reg),
        .d      (d_reg),
        .p_next (p_step),
        .q_next (q_step)
    );

    // Magnitudes fit the unsigned width, so -2^(W-1) survives negation intact.
    assign dvd_mag  = (i_sign && i_dividend[DATA_WIDTH-1]) ? -i_dividend : i_dividend;
    assign dvs_mag  = (i_sign && i_divisor[DATA_WIDTH-1])  ? -i_divisor  : i_divisor;
    assign dvs_zero = (i_divisor == '0);
    assign ovf      = i_sign && (i_dividend == MOST_NEG) && (i_divisor == '1);

    assign p_fix    = p_reg[DATA_WIDTH] ? (p_reg + {1'b0, d_reg}) : p_reg;
    assign quo_fix  = quo_neg ? -q_reg : q_reg;
    assign rem_fix  = rem_neg ? -p_fix[DATA_WIDTH-1:0] : p_fix[DATA_WIDTH-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            p_reg   <= '0;
            q_reg   <= '0;
            d_reg   <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            o_rdy   <= 1'b1;
            o_vld   <= 1'b0;
            o_busy  <= 1'b0;
            o_quo   <= '0;
            o_rem   <= '0;
        end else if (i_flush) begin
            state  <= DIV_IDLE;
            o_rdy  <= 1'b1;
            o_vld  <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (i_vld) begin
                        o_rdy <= 1'b0;
                        if (dvs_zero) begin
                            o_quo <= DIV_ZERO_QUO[DATA_WIDTH-1:0];
                            o_rem <= i_dividend;
                            o_vld <= 1'b1;
                            state <= DIV_DONE;
                        end else if (ovf) begin
                            o_quo <= i_dividend;
                            o_rem <= '0;
                            o_vld <= 1'b1;
                            state <= DIV_DONE;
                        end else begin
                            p_reg   <= '0;
                            q_reg   <= dvd_mag;
                            d_reg   <= dvs_mag;
                            quo_neg <= i_sign && (i_dividend[DATA_WIDTH-1] ^ i_divisor[DATA_WIDTH-1]);
                            rem_neg <= i_sign && i_dividend[DATA_WIDTH-1];
                            cnt     <= CNT_WIDTH'(DATA_WIDTH);
                            o_busy  <= 1'b1;
                            state   <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    p_reg <= p_step;
                    q_reg <= q_step;
                    cnt   <= cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) begin
                        state <= DIV_FIXUP;
                    end
                end
                DIV_FIXUP: begin
                    o_quo  <= quo_fix;
                    o_rem  <= rem_fix;
                    o_busy <= 1'b0;
                    o_vld  <= 1'b1;
                    state  <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (i_rdy) begin
                        o_vld <= 1'b0;
                        o_rdy <= 1'b1;
                        state <= DIV_IDLE;
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_32bit_nonrestore.sv
// Randomized and directed bench for div_32bit_nonrestore against a plain-arithmetic model.
module tb_div_32bit_nonrestore;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         flush  = 1'b0;
    logic         vld    = 1'b0;
    logic         sign   = 1'b0;
    logic         rdy_in = 1'b0;
    logic [W-1:0] dvd    = '0;
    logic [W-1:0] dvs    = '0;
    logic         rdy_out;
    logic         vld_out;
    logic         busy;
    logic [W-1:0] quo;
    logic [W-1:0] rem;

    int checks = 0;
    int errors = 0;

    logic         exp_on = 1'b0;
    logic [W-1:0] exp_q  = '0;
    logic [W-1:0] exp_r  = '0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    always #5 clk = ~clk;

    div_32bit_nonrestore #(
        .DATA_WIDTH (W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_vld      (vld),
        .o_rdy      (rdy_out),
        .i_sign     (sign),
        .i_dividend (dvd),
        .i_divisor  (dvs),
        .o_vld      (vld_out),
        .i_rdy      (rdy_in),
        .o_quo      (quo),
        .o_rem      (rem),
        .o_busy     (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: SV integer division truncates toward zero and % takes the dividend's sign,
    // computed at 64 bits so that -2^31 / -1 wraps back to -2^31 when cut to 32 bits.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        longint tq;
        longint tr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[W-1:0];
            r  = tr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Every cycle a result is presented it must match the model and be stable.
    always @(negedge clk) begin
        if (rst_n && vld_out) begin
            if (!exp_on) begin
                check("unexpected_vld", {63'd0, vld_out}, 64'd0);
            end else begin
                check("quo", {32'd0, quo}, {32'd0, exp_q});
                check("rem", {32'd0, rem}, {32'd0, exp_r});
                check("rdy_in_done", {63'd0, rdy_out}, 64'd0);
                check("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Latency counts clock edges from the accept edge to the edge where the result can be taken.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int hold, output int lat);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        logic [63:0] uprod;
        int n;
        n = 0;
        while (!rdy_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_out) check("rdy_timeout", {63'd0, rdy_out}, 64'd1);
        model(a, b, s, eq, er);
        dvd = a;
        dvs = b;
        sign = s;
        vld = 1'b1;
        rdy_in = 1'b0;
        @(posedge clk);
        exp_q = eq;
        exp_r = er;
        exp_on = 1'b1;
        #1;
        vld  = 1'b0;
        dvd  = $urandom;
        dvs  = $urandom;
        sign = 1'($urandom_range(0, 1));
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (vld_out) break;
        end
        check("vld_timeout", {63'd0, vld_out}, 64'd1);
        last_q = quo;
        last_r = rem;
        if (b != '0 && !(s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            if (s) begin
                sa = longint'(signed'(a));
                sb = longint'(signed'(b));
                sq = longint'(signed'(quo));
                sr = longint'(signed'(rem));
                check("identity_s", sq * sb + sr, sa);
                if (sr < 0) sr = -sr;
                if (sb < 0) sb = -sb;
                check("rem_bound_s", {63'd0, sr < sb}, 64'd1);
            end else begin
                uprod = {32'd0, quo} * {32'd0, b} + {32'd0, rem};
                check("identity_u", uprod, {32'd0, a});
                check("rem_bound_u", {63'd0, rem < b}, 64'd1);
            end
        end
        repeat (hold) begin
            @(negedge clk);
            check("hold_vld", {63'd0, vld_out}, 64'd1);
        end
        rdy_in = 1'b1;
        @(posedge clk);
        exp_on = 1'b0;
        #1 rdy_in = 1'b0;
        @(negedge clk);
        check("vld_drop", {63'd0, vld_out}, 64'd0);
        check("rdy_back", {63'd0, rdy_out}, 64'd1);
    endtask

    task automatic run_dir(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [W-1:0] rq, input logic [W-1:0] rr,
                           input int rlat);
        int lat;
        do_op(a, b, s, 0, lat);
        check({name, "_quo"}, {32'd0, last_q}, {32'd0, rq});
        check({name, "_rem"}, {32'd0, last_r}, {32'd0, rr});
        check({name, "_lat"}, 64'(lat), 64'(rlat));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] prev_q;
        logic         s;
        int lat;
        int exp_lat;

        // Pin the model itself against hand-worked values.
        model(32'd100, 32'd7, 1'b0, mq, mr);
        check("model_100_7_q", {32'd0, mq}, 64'd14);
        check("model_100_7_r", {32'd0, mr}, 64'd2);
        model(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr);
        check("model_m7_2_q", {32'd0, mq}, 64'hFFFF_FFFD);
        check("model_m7_2_r", {32'd0, mr}, 64'hFFFF_FFFF);
        model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr);
        check("model_ovf_q", {32'd0, mq}, 64'h8000_0000);

        repeat (3) @(negedge clk);
        check("rst_rdy", {63'd0, rdy_out}, 64'd1);
        check("rst_vld", {63'd0, vld_out}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_quo", {32'd0, quo}, 64'd0);
        check("rst_rem", {32'd0, rem}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_dir("u100_7",   32'd100,         32'd7,           1'b0, 32'd14,          32'd2,          34);
        run_dir("sm7_2",    32'hFFFF_FFF9,   32'd2,           1'b1, 32'hFFFF_FFFD,   32'hFFFF_FFFF,  34);
        run_dir("s7_m2",    32'd7,           32'hFFFF_FFFE,   1'b1, 32'hFFFF_FFFD,   32'd1,          34);
        run_dir("u_div0",   32'hDEAD_BEEF,   32'd0,           1'b0, 32'hFFFF_FFFF,   32'hDEAD_BEEF,  1);
        run_dir("s_div0",   32'hFFFF_FFFB,   32'd0,           1'b1, 32'hFFFF_FFFF,   32'hFFFF_FFFB,  1);
        run_dir("s_ovf",    32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 32'h8000_0000,   32'd0,          1);
        run_dir("u_ovfops", 32'h8000_0000,   32'hFFFF_FFFF,   1'b0, 32'd0,           32'h8000_0000,  34);
        run_dir("s_minby1", 32'h8000_0000,   32'd1,           1'b1, 32'h8000_0000,   32'd0,          34);

        // Result held under back-pressure; monitor checks stability and o_rdy low each cycle.
        do_op(32'd1000, 32'd33, 1'b0, 5, lat);

        // Flush during CALC: back to IDLE, no result, outputs keep their last values.
        prev_q = quo;
        dvd = 32'd12345; dvs = 32'd17; sign = 1'b0; vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_rdy", {63'd0, rdy_out}, 64'd1);
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_quo_kept", {32'd0, quo}, {32'd0, prev_q});
        repeat (40) @(negedge clk);
        check("flush_no_vld", {63'd0, vld_out}, 64'd0);

        // Flush on the accept edge drops the request.
        dvd = 32'd9; dvs = 32'd0; sign = 1'b0; vld = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_acc_rdy", {63'd0, rdy_out}, 64'd1);
        check("flush_acc_vld", {63'd0, vld_out}, 64'd0);

        // Asynchronous reset mid-CALC clears outputs without a clock edge.
        dvd = 32'd777; dvs = 32'd5; sign = 1'b0; vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rdy", {63'd0, rdy_out}, 64'd1);
        check("arst_vld", {63'd0, vld_out}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_quo", {32'd0, quo}, 64'd0);
        check("arst_rem", {32'd0, rem}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_dir("post_rst", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 34);

        for (int k = 0; k < 1000; k++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'($urandom_range(0, 15));
                1: b = 32'(-$urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            exp_lat = (b == '0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
            do_op(a, b, s, $urandom_range(0, 2), lat);
            check("rand_lat", 64'(lat), 64'(exp_lat));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
